// File: rtl/au_add_csv_acc_if.sv
// Stream bus for au_add_csv_acc: operand input handshake plus result output handshake.
// The accumulator takes the slave modport; the producer/consumer side takes master.
interface au_add_csv_acc_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/au_add_csv_acc.sv
// Streaming carry-save accumulator with a chunked multi-cycle resolve adder.
// Optional operand counter / overflow flag enabled by macro AU_ADD_CSV_ACC_CNT_EN.
module au_add_csv_acc #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CHUNK     = 4,
    parameter int SIGNED    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    au_add_csv_acc_if.slave bus
`ifdef AU_ADD_CSV_ACC_CNT_EN
    ,
    output logic [15:0]     out_cnt,
    output logic            out_ovf
`endif
);
    localparam int NCHUNK = (ACC_WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {ST_ACC, ST_RESOLVE, ST_OUT} state_t;

    state_t               state_r, state_nxt;
    logic [ACC_WIDTH-1:0] sum_r, carry_r, result_r, x_ext;
    logic [IDX_W-1:0]     idx_r;
    logic                 cpa_c_r, out_valid_r;
    logic                 accept, handshake, last_chunk;
    logic [31:0]          chunk_off;
    logic [CHUNK-1:0]     chunk_s, chunk_c;
    logic [CHUNK:0]       chunk_add;
    logic [ACC_WIDTH-1:0] chunk_mask, chunk_val;

    if (SIGNED != 0) begin : g_sext
        assign x_ext = ACC_WIDTH'($signed(bus.in_data));
    end else begin : g_zext
        assign x_ext = ACC_WIDTH'(bus.in_data);
    end

    // Shifting right zero-fills, so a narrow top chunk needs no special case.
    assign last_chunk = (idx_r == LAST_IDX);
    assign chunk_off  = 32'(idx_r) * CHUNK;
    assign chunk_s    = CHUNK'(sum_r >> chunk_off);
    assign chunk_c    = CHUNK'(carry_r >> chunk_off);
    assign chunk_add  = {1'b0, chunk_s} + {1'b0, chunk_c} + {{CHUNK{1'b0}}, cpa_c_r};
    assign chunk_mask = ACC_WIDTH'({CHUNK{1'b1}}) << chunk_off;
    assign chunk_val  = ACC_WIDTH'(chunk_add[CHUNK-1:0]) << chunk_off;

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = result_r;

    // Next-state and handshake decode; clr overrides everything and blocks input.
    always_comb begin
        state_nxt    = state_r;
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        handshake    = 1'b0;
        case (state_r)
            ST_ACC: begin
                bus.in_ready = !clr;
                accept       = bus.in_valid && !clr;
                if (accept && bus.in_last) state_nxt = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (last_chunk) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                handshake = out_valid_r && bus.out_ready;
                if (handshake) state_nxt = ST_ACC;
            end
            default: state_nxt = ST_ACC;
        endcase
        if (clr) state_nxt = ST_ACC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_ACC;
        else        state_r <= state_nxt;
    end

    // out_valid is registered, so it rises one cycle after the resolve completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= '0;
            carry_r     <= '0;
            result_r    <= '0;
            cpa_c_r     <= 1'b0;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (clr) begin
            sum_r       <= '0;
            carry_r     <= '0;
            cpa_c_r     <= 1'b0;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept) begin
                sum_r   <= sum_r ^ carry_r ^ x_ext;
                carry_r <= ((sum_r & carry_r) | (sum_r & x_ext) | (carry_r & x_ext)) << 1;
            end
            if (state_r == ST_RESOLVE) begin
                result_r <= (result_r & ~chunk_mask) | chunk_val;
                cpa_c_r  <= chunk_add[CHUNK];
                idx_r    <= last_chunk ? '0 : idx_r + IDX_W'(1);
            end
            if (state_r == ST_OUT && !out_valid_r) out_valid_r <= 1'b1;
            if (handshake) begin
                sum_r       <= '0;
                carry_r     <= '0;
                cpa_c_r     <= 1'b0;
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef AU_ADD_CSV_ACC_CNT_EN
    localparam int HEAD = ACC_WIDTH - WIDTH;

    logic [15:0] cnt_r, cnt_inc;
    logic        ovf_r;

    assign cnt_inc = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
    assign out_cnt = cnt_r;
    assign out_ovf = ovf_r;

    // Overflow means more operands than the headroom bits can absorb exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (clr || handshake) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            cnt_r <= cnt_inc;
            if ((HEAD < 16) && (32'(cnt_inc) > (32'd1 << HEAD))) ovf_r <= 1'b1;
        end
    end
`endif
endmodule

// File: doc/au_add_csv_acc.md
Name: au_add_csv_acc

Overview:
- Streaming multi-operand accumulator built on the team's 3:2 carry-save cell, generalised from one-shot three-operand reduction to an unbounded operand stream.
- Keeps the running sum in redundant (sum, carry) form with one CSA level per accepted operand, so per-beat timing is independent of ACC_WIDTH.
- On the packet's last beat it resolves the sum with a chunked multi-cycle carry-propagate adder and presents the result on a valid/ready output.
- Sits in the AU datapath as the reduction stage for dot-product and checksum units.

Parameters:
- WIDTH, 8, operand width.
- ACC_WIDTH, 16, accumulator and result width. Must be >= WIDTH.
- CHUNK, 4, CPA bits resolved per cycle. Must be >= 1. NCHUNK = ceil(ACC_WIDTH/CHUNK).
- SIGNED, 0, operand extension: 0 = zero-extend, 1 = sign-extend to ACC_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear / abort.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accept.
- in_data  input  WIDTH  operand.
- in_last  input  1  final operand of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  result accept.
- out_data  output  ACC_WIDTH  resolved sum, modulo 2^ACC_WIDTH.

Behaviour:
- Reset (rst_n=0, asynchronous): state ACC; sum_r, carry_r, result_r and CPA carry all 0; out_valid=0; out_data=0; in_ready=1 once rst_n is released.
- Invariant: the packet value is (sum_r + carry_r) mod 2^ACC_WIDTH. x is in_data extended per SIGNED.
- ACC state:
  - in_ready=1.
  - Accept on in_valid&in_ready: sum_r <= sum_r^carry_r^x; carry_r <= maj(sum_r,carry_r,x)<<1, truncated to ACC_WIDTH.
  - Accepting with in_last=1 moves the state to RESOLVE on the next cycle. Every packet holds at least one operand.
- RESOLVE state:
  - in_ready=0.
  - Cycle k (0..NCHUNK-1) adds chunk k of sum_r and carry_r plus the stored chunk carry, then writes chunk k of result_r.
  - The top chunk may be narrower than CHUNK. The carry out of bit ACC_WIDTH-1 is discarded.
  - After chunk NCHUNK-1 the state moves to OUT.
- OUT state:
  - out_valid=1 and in_ready=0. out_data=result_r, held stable while out_ready=0.
  - On out_valid&out_ready: sum_r, carry_r and the chunk carry clear to 0, state returns to ACC, and in_ready=1 from the next cycle. There is no same-cycle bypass.
- Latency: last beat accepted at edge T gives out_valid=1 after edge T+NCHUNK+1. Throughput is one operand per cycle within a packet.
- clr=1 at any edge, highest priority:
  - state goes to ACC; sum_r, carry_r and the chunk carry go to 0; out_valid goes to 0. result_r is unchanged.
  - An in_valid beat presented in the same cycle is not accepted, because in_ready is forced to 0 while clr=1.
  - clr during RESOLVE or OUT discards the pending result.
- out_data outside OUT keeps the last result (0 after reset). Consumers qualify it with out_valid.
- Wrap-around: sums wrap modulo 2^ACC_WIDTH with no saturation.

Optional Feature:
- Macro: AU_ADD_CSV_ACC_CNT_EN.
- When defined, two extra outputs are added:
  - out_cnt (16 bits): operands in the current packet. Saturates at 0xFFFF. Clears with the accumulator.
  - out_ovf (1 bit): sticky per packet. Set when out_cnt exceeds 2^(ACC_WIDTH-WIDTH), meaning the sum is no longer guaranteed exact. Valid with out_valid.
- When not defined, neither port nor counter logic exists, and behaviour is otherwise identical.

Test Plan:
Configuration WIDTH=8, ACC_WIDTH=12, CHUNK=4 (NCHUNK=3) unless noted.
- Reset check: rst_n low, then high -> out_valid=0, out_data=0x000, in_ready=1. Assert rst_n mid-RESOLVE -> out_valid stays 0 and the next packet starts from 0.
- Sixteen beats of 0xFF, last on the 16th -> out_data=0xFF0, out_valid rising after edge T+4. With CNT_EN: out_cnt=16, out_ovf=0.
- Seventeen beats of 0xFF -> out_data=0x0EF (wrap). With CNT_EN: out_cnt=17, out_ovf=1.
- SIGNED=1: beats 0x80, then 0x01 with last -> out_data=0xF81.
- Backpressure: hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0, offered beats not accepted. After the handshake, a single beat 0x05 with last -> 0x005.
- clr: beats 0x10 and 0x20, then clr=1 with in_valid=1, in_data=0x30 -> beat dropped. Then 0x07 with last -> 0x007. Repeat with clr during RESOLVE -> no out_valid for that packet.
